// File: rtl/pic_config_sequencer_if.sv
// Handshake and bus bundle between a PIC configuration requester and the sequencer.
// Signal names follow the PIC pin names so that waveforms read like the datasheet.
interface pic_config_sequencer_if;
  logic       start;
  logic       cfg_ltim;
  logic       cfg_sngl;
  logic       cfg_ic4;
  logic [4:0] cfg_vector_base;
  logic [7:0] cfg_icw3;
  logic       cfg_aeoi;
  logic       cfg_ms;
  logic       cfg_buf;
  logic       ocw_req;
  logic [1:0] ocw_sel;
  logic [7:0] ocw_data;
  logic       WD;
  logic       A0;
  logic [7:0] data_out;
  logic       data_oe;
  logic       busy;
  logic       init_done;
  logic       ocw_ack;
  logic       ocw_err;

  modport master (
    output start, cfg_ltim, cfg_sngl, cfg_ic4, cfg_vector_base, cfg_icw3,
    output cfg_aeoi, cfg_ms, cfg_buf, ocw_req, ocw_sel, ocw_data,
    input  WD, A0, data_out, data_oe, busy, init_done, ocw_ack, ocw_err
  );

  modport slave (
    input  start, cfg_ltim, cfg_sngl, cfg_ic4, cfg_vector_base, cfg_icw3,
    input  cfg_aeoi, cfg_ms, cfg_buf, ocw_req, ocw_sel, ocw_data,
    output WD, A0, data_out, data_oe, busy, init_done, ocw_ack, ocw_err
  );
endinterface

// File: rtl/pic_config_sequencer.sv
// Drives the ICW1..ICW4 initialization writes and single OCW writes into an 8259-style PIC,
// each write as SETUP / STROBE (WR_PULSE cycles, WD low) / HOLD.
module pic_config_sequencer #(
  parameter int unsigned WR_PULSE = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  pic_config_sequencer_if.slave bus_io
);

  typedef enum logic [2:0] {
    StUninit, StIcw1, StIcw2, StIcw3, StIcw4, StReady, StOcw
  } state_e;

  typedef enum logic [1:0] {PhSetup, PhStrobe, PhHold} phase_e;

  typedef struct packed {
    logic       ltim;
    logic       sngl;
    logic       ic4;
    logic [4:0] base;
    logic [7:0] icw3;
    logic       aeoi;
    logic       ms;
    logic       buf_en;
  } cfg_t;

  localparam logic [3:0] StrobeLast = 4'(WR_PULSE - 1);

  // Returns {A0, data} for an initialization word.
  function automatic logic [8:0] icw_word(input state_e s, input cfg_t c);
    unique case (s)
      StIcw1:  return {1'b0, 3'b000, 1'b1, c.ltim, 1'b0, c.sngl, c.ic4};
      StIcw2:  return {1'b1, c.base, 3'b000};
      StIcw3:  return {1'b1, c.icw3};
      StIcw4:  return {1'b1, 3'b000, 1'b0, c.buf_en, c.ms, c.aeoi, 1'b1};
      default: return 9'h000;
    endcase
  endfunction

  // OCW2/OCW3 force their identifying bits so a bad payload cannot alias another register.
  function automatic logic [8:0] ocw_word(input logic [1:0] sel, input logic [7:0] d);
    unique case (sel)
      2'd0:    return {1'b1, d};
      2'd1:    return {1'b0, d[7:5], 2'b00, d[2:0]};
      default: return {1'b0, 1'b0, d[6:5], 2'b01, d[2:0]};
    endcase
  endfunction

  function automatic state_e next_write(input state_e s, input cfg_t c);
    unique case (s)
      StIcw1:  return StIcw2;
      StIcw2:  return !c.sngl ? StIcw3 : (c.ic4 ? StIcw4 : StReady);
      StIcw3:  return c.ic4 ? StIcw4 : StReady;
      default: return StReady;
    endcase
  endfunction

  state_e     state_q, state_d, nxt;
  phase_e     phase_q, phase_d;
  logic [3:0] cnt_q, cnt_d;
  cfg_t       cfg_q, cfg_d, cfg_in, cfg_sel;
  logic       a0_q, a0_d;
  logic [7:0] data_q, data_d;
  logic       init_done_q, init_done_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;
  logic       accept;
  logic       busy;

  assign cfg_in = {bus_io.cfg_ltim, bus_io.cfg_sngl, bus_io.cfg_ic4, bus_io.cfg_vector_base,
                   bus_io.cfg_icw3, bus_io.cfg_aeoi, bus_io.cfg_ms, bus_io.cfg_buf};

  assign busy    = (state_q != StUninit) && (state_q != StReady);
  assign accept  = bus_io.start && !busy;
  // ICW1 is loaded on the accept edge, before the configuration register holds the new values.
  assign cfg_sel = accept ? cfg_in : cfg_q;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    cfg_d       = cfg_q;
    a0_d        = a0_q;
    data_d      = data_q;
    init_done_d = init_done_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    nxt         = StReady;

    if (accept) begin
      cfg_d          = cfg_in;
      state_d        = StIcw1;
      phase_d        = PhSetup;
      init_done_d    = 1'b0;
      {a0_d, data_d} = icw_word(StIcw1, cfg_sel);
    end else begin
      unique case (state_q)
        StUninit: err_d = bus_io.ocw_req;
        StReady: begin
          if (bus_io.ocw_req) begin
            if (bus_io.ocw_sel == 2'd3) begin
              err_d = 1'b1;
            end else begin
              state_d        = StOcw;
              phase_d        = PhSetup;
              {a0_d, data_d} = ocw_word(bus_io.ocw_sel, bus_io.ocw_data);
            end
          end
        end
        default: begin
          unique case (phase_q)
            PhSetup: begin
              phase_d = PhStrobe;
              cnt_d   = '0;
            end
            PhStrobe: begin
              if (cnt_q == StrobeLast) phase_d = PhHold;
              else                     cnt_d   = cnt_q + 4'd1;
            end
            default: begin
              nxt     = next_write(state_q, cfg_q);
              state_d = nxt;
              phase_d = PhSetup;
              if (nxt == StReady) begin
                if (state_q == StOcw) ack_d       = 1'b1;
                else                  init_done_d = 1'b1;
              end else begin
                {a0_d, data_d} = icw_word(nxt, cfg_sel);
              end
            end
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StUninit;
      phase_q     <= PhSetup;
      cnt_q       <= '0;
      cfg_q       <= '0;
      a0_q        <= 1'b0;
      data_q      <= 8'h00;
      init_done_q <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      cfg_q       <= cfg_d;
      a0_q        <= a0_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
    end
  end

  // WD decodes straight from state so an asynchronous reset releases it immediately.
  assign bus_io.WD        = !(busy && (phase_q == PhStrobe));
  assign bus_io.A0        = a0_q;
  assign bus_io.data_out  = data_q;
  assign bus_io.data_oe   = busy;
  assign bus_io.busy      = busy;
  assign bus_io.init_done = init_done_q;
  assign bus_io.ocw_ack   = ack_q;
  assign bus_io.ocw_err   = err_q;

endmodule

// File: tb/tb_pic_config_sequencer.sv
// Bench for pic_config_sequencer: a queue-based write-schedule model checked every cycle,
// plus directed scenarios with literal expectations and a randomized traffic phase.
module tb_pic_config_sequencer;
  localparam int unsigned WR_PULSE = 2;
  localparam int          BOUND    = 300;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pic_config_sequencer_if bus ();

  pic_config_sequencer #(.WR_PULSE(WR_PULSE)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h want 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model: list of writes expanded into cycles ----------------
  typedef struct packed {
    logic       wd;
    logic       a0;
    logic [7:0] data;
    logic       oe;
    logic       busy;
    logic       done;
    logic       ack;
    logic       err;
  } out_t;

  out_t       exp_q[$];
  out_t       cur;
  bit         m_ready;
  bit         m_done;
  logic       m_a0;
  logic [7:0] m_data;

  function automatic out_t idle_out(input logic ack, input logic err);
    out_t o;
    o.wd = 1'b1; o.a0 = m_a0; o.data = m_data; o.oe = 1'b0; o.busy = 1'b0;
    o.done = m_done; o.ack = ack; o.err = err;
    return o;
  endfunction

  task automatic push_write(input logic a0, input logic [7:0] d);
    out_t o;
    o.a0 = a0; o.data = d; o.oe = 1'b1; o.busy = 1'b1; o.done = m_done;
    o.ack = 1'b0; o.err = 1'b0;
    o.wd = 1'b1;
    exp_q.push_back(o);
    o.wd = 1'b0;
    repeat (WR_PULSE) exp_q.push_back(o);
    o.wd = 1'b1;
    exp_q.push_back(o);
    m_a0   = a0;
    m_data = d;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ready = 1'b0;
    m_done  = 1'b0;
    m_a0    = 1'b0;
    m_data  = 8'h00;
    cur     = idle_out(1'b0, 1'b0);
  endtask

  task automatic model_step();
    logic [7:0] d;
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
    end else if (bus.start) begin
      m_done = 1'b0;
      push_write(1'b0, 8'h10 | ({7'd0, bus.cfg_ltim} << 3) | ({7'd0, bus.cfg_sngl} << 1)
                       | {7'd0, bus.cfg_ic4});
      push_write(1'b1, {3'd0, bus.cfg_vector_base} * 8'd8);
      if (!bus.cfg_sngl) push_write(1'b1, bus.cfg_icw3);
      if (bus.cfg_ic4)
        push_write(1'b1, 8'h01 | ({7'd0, bus.cfg_aeoi} << 1) | ({7'd0, bus.cfg_ms} << 2)
                         | ({7'd0, bus.cfg_buf} << 3));
      m_ready = 1'b1;
      m_done  = 1'b1;
      exp_q.push_back(idle_out(1'b0, 1'b0));
      cur = exp_q.pop_front();
    end else if (bus.ocw_req) begin
      if (!m_ready || bus.ocw_sel == 2'd3) begin
        cur = idle_out(1'b0, 1'b1);
      end else begin
        d = bus.ocw_data;
        case (bus.ocw_sel)
          2'd0:    push_write(1'b1, d);
          2'd1:    push_write(1'b0, d & 8'hE7);
          default: push_write(1'b0, (d & 8'h67) | 8'h08);
        endcase
        exp_q.push_back(idle_out(1'b1, 1'b0));
        cur = exp_q.pop_front();
      end
    end else begin
      cur = idle_out(1'b0, 1'b0);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  out_t act;
  initial forever begin
    @(negedge clk);
    act = {bus.WD, bus.A0, bus.data_out, bus.data_oe, bus.busy, bus.init_done,
           bus.ocw_ack, bus.ocw_err};
    chk("outputs", act, cur);
  end

  // ---------------- write monitor: (A0,data) at each WD fall, WD-low run lengths ----------------
  logic       prev_wd = 1'b1;
  int         low_run = 0;
  logic [8:0] obs[$];
  int         low_q[$];
  initial forever begin
    @(negedge clk);
    if (!bus.WD && prev_wd) obs.push_back({bus.A0, bus.data_out});
    if (!bus.WD) low_run++;
    else if (!prev_wd) begin
      low_q.push_back(low_run);
      low_run = 0;
    end
    prev_wd = bus.WD;
  end

  initial begin
    #400000;
    $display("FAIL watchdog at %0t: got no finish want finish", $time);
    $fatal(1);
  end

  // ---------------- stimulus helpers (all start and end on a falling edge) ----------------
  task automatic scramble_cfg();
    bus.cfg_ltim        = 1'($urandom);
    bus.cfg_sngl        = 1'($urandom);
    bus.cfg_ic4         = 1'($urandom);
    bus.cfg_vector_base = 5'($urandom);
    bus.cfg_icw3        = 8'($urandom);
    bus.cfg_aeoi        = 1'($urandom);
    bus.cfg_ms          = 1'($urandom);
    bus.cfg_buf         = 1'($urandom);
  endtask

  task automatic do_start(input logic ltim, input logic sngl, input logic ic4,
                          input logic [4:0] base, input logic [7:0] icw3,
                          input logic aeoi, input logic ms, input logic bufv);
    bus.cfg_ltim = ltim; bus.cfg_sngl = sngl; bus.cfg_ic4 = ic4;
    bus.cfg_vector_base = base; bus.cfg_icw3 = icw3;
    bus.cfg_aeoi = aeoi; bus.cfg_ms = ms; bus.cfg_buf = bufv;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    scramble_cfg();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.init_done && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    chk("ready_in_time", 32'(n < BOUND), 32'd1);
  endtask

  task automatic ocw_request(input logic [1:0] sel, input logic [7:0] d, input int want,
                             output int acks, output int errs);
    int n;
    bus.ocw_sel  = sel;
    bus.ocw_data = d;
    bus.ocw_req  = 1'b1;
    acks = 0; errs = 0; n = 0;
    while (acks < want && errs == 0 && n < BOUND) begin
      @(negedge clk);
      n++;
      if (bus.ocw_ack) acks++;
      if (bus.ocw_err) errs++;
    end
    bus.ocw_req = 1'b0;
    chk("ocw_in_time", 32'(n < BOUND), 32'd1);
  endtask

  int n, a, e, nobs, nlow;

  initial begin
    bus.start = 1'b0; bus.ocw_req = 1'b0; bus.ocw_sel = 2'd0; bus.ocw_data = 8'h00;
    scramble_cfg();
    repeat (3) @(negedge clk);
    chk("rst_wd", bus.WD, 1);
    chk("rst_data", bus.data_out, 0);
    chk("rst_done", bus.init_done, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // OCW before initialization is rejected without a write
    nobs = obs.size();
    ocw_request(2'd0, 8'hA5, 1, a, e);
    chk("preinit_err", e, 1);
    chk("preinit_ack", a, 0);
    chk("preinit_nowrite", obs.size(), nobs);

    // single PIC, no ICW4
    nobs = obs.size(); nlow = low_q.size();
    do_start(1'b0, 1'b1, 1'b0, 5'h08, 8'h00, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!bus.init_done && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    chk("init_latency", n, 8);
    chk("short_init_writes", obs.size() - nobs, 2);
    chk("icw1_single", obs[nobs], 9'h012);
    chk("icw2_base08", obs[nobs+1], 9'h140);
    chk("icw1_wd_low", low_q[nlow], WR_PULSE);
    chk("icw2_wd_low", low_q[nlow+1], WR_PULSE);

    // OCW1 after initialization
    ocw_request(2'd0, 8'hA5, 1, a, e);
    chk("ocw1_ack", a, 1);
    chk("ocw1_write", obs[obs.size()-1], 9'h1A5);

    ocw_request(2'd2, 8'hFF, 1, a, e);
    chk("ocw3_write", obs[obs.size()-1], 9'h06F);
    ocw_request(2'd1, 8'hFF, 1, a, e);
    chk("ocw2_write", obs[obs.size()-1], 9'h0E7);
    nobs = obs.size();
    ocw_request(2'd3, 8'h55, 1, a, e);
    chk("illegal_sel_err", e, 1);
    chk("illegal_sel_nowrite", obs.size(), nobs);

    // cascaded master with ICW3 and ICW4
    nobs = obs.size();
    do_start(1'b0, 1'b0, 1'b1, 5'h11, 8'h04, 1'b1, 1'b1, 1'b1);
    wait_ready(n);
    chk("full_init_writes", obs.size() - nobs, 4);
    chk("icw1_cascade", obs[nobs], 9'h011);
    chk("icw2_base11", obs[nobs+1], 9'h188);
    chk("icw3_value", obs[nobs+2], 9'h104);
    chk("icw4_value", obs[nobs+3], 9'h10F);

    // request held through the ack is served again
    nobs = obs.size();
    ocw_request(2'd0, 8'h5A, 2, a, e);
    chk("held_req_acks", a, 2);
    chk("held_req_writes", obs.size() - nobs, 2);

    // start and OCW together: init first, then the OCW
    nobs = obs.size();
    bus.cfg_ltim = 1'b0; bus.cfg_sngl = 1'b1; bus.cfg_ic4 = 1'b1; bus.cfg_vector_base = 5'h02;
    bus.cfg_aeoi = 1'b0; bus.cfg_ms = 1'b0; bus.cfg_buf = 1'b0;
    bus.ocw_sel = 2'd0; bus.ocw_data = 8'h3C; bus.ocw_req = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    scramble_cfg();
    n = 0;
    while (!bus.ocw_ack && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    bus.ocw_req = 1'b0;
    chk("combo_ack_seen", bus.ocw_ack, 1);
    chk("combo_writes", obs.size() - nobs, 4);
    chk("combo_icw1", obs[nobs], 9'h013);
    chk("combo_ocw_last", obs[obs.size()-1], 9'h13C);

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 2) begin
        do_start(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 8'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom));
        wait_ready(n);
      end else if (op <= 7) begin
        ocw_request(2'($urandom), 8'($urandom), 1, a, e);
      end else if (op == 8) begin
        do_start(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 8'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom));
        repeat ($urandom_range(1, 5)) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_ready(n);
      end else begin
        scramble_cfg();
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
    end

    // reset in the middle of the ICW2 strobe
    do_start(1'b0, 1'b1, 1'b0, 5'h08, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("icw2_strobe_wd", bus.WD, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_wd", bus.WD, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_oe", bus.data_oe, 0);
    chk("abort_a0", bus.A0, 0);
    chk("abort_data", bus.data_out, 0);
    chk("abort_done", bus.init_done, 0);
    chk("abort_ack_err", {bus.ocw_ack, bus.ocw_err}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    nobs = obs.size();
    do_start(1'b0, 1'b1, 1'b0, 5'h08, 8'h00, 1'b0, 1'b0, 1'b0);
    wait_ready(n);
    chk("replay_writes", obs.size() - nobs, 2);
    chk("replay_icw1", obs[nobs], 9'h012);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pic_config_sequencer.md
PIC_CONFIG_SEQUENCER -- requirements
Module: pic_config_sequencer

Interface
REQ-001 Parameter WR_PULSE, default 2, number of clk cycles WD is held low per write (legal 1..15).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low; synchronous deassert to clk.
REQ-004 start  in  1  one-cycle request to run the ICW1..ICW4 initialization sequence.
REQ-005 cfg_ltim, cfg_sngl, cfg_ic4  in  1 each  ICW1 LTIM, SNGL and IC4 values.
REQ-006 cfg_vector_base  in  5  ICW2 bits T7..T3.
REQ-007 cfg_icw3  in  8  ICW3 value (slave map or slave ID).
REQ-008 cfg_aeoi, cfg_ms, cfg_buf  in  1 each  ICW4 AEOI, M/S and BUF values.
REQ-009 ocw_req  in  1  level request for one OCW write, held until ocw_ack or ocw_err.
REQ-010 ocw_sel  in  2  0=OCW1, 1=OCW2, 2=OCW3, 3=illegal.
REQ-011 ocw_data  in  8  OCW payload.
REQ-012 WD  out  1  active-low write strobe to the PIC control logic.
REQ-013 A0  out  1  PIC register select.
REQ-014 data_out  out  8  write data; data_oe  out  1  data bus drive enable.
REQ-015 busy  out  1  write sequence in progress; init_done  out  1  ICWs complete.
REQ-016 ocw_ack, ocw_err  out  1 each  one-cycle completion / rejection pulses.

Function
REQ-017 Top FSM states: UNINIT, ICW1, ICW2, ICW3, ICW4, READY, OCW.
REQ-018 Each write state uses phases SETUP (1 cycle, A0/data_out valid, data_oe=1, WD=1), STROBE (WR_PULSE cycles, WD=0), HOLD (1 cycle, WD=1, data held); one write = WR_PULSE+2 cycles.
REQ-019 start accepted only in UNINIT or READY; all cfg_* inputs latched on the accept edge, later changes ignored until next accept.
REQ-020 start in ICW1..ICW4 or OCW is ignored.
REQ-021 ICW1: A0=0, data={000,1,ltim,0,sngl,ic4}; then ICW2.
REQ-022 ICW2: A0=1, data={vector_base,000}; then ICW3 if sngl=0, else ICW4 if ic4=1, else READY.
REQ-023 ICW3: A0=1, data=cfg_icw3; then ICW4 if ic4=1, else READY.
REQ-024 ICW4: A0=1, data={000,0,buf,ms,aeoi,1}; then READY.
REQ-025 init_done cleared on start accept; set on the cycle after the final HOLD, entering READY.
REQ-026 busy=1 exactly from the first SETUP cycle to the last HOLD cycle inclusive.
REQ-027 In READY, ocw_req with ocw_sel 0..2 enters OCW; OCW1: A0=1, data=ocw_data; OCW2: A0=0, data={ocw_data[7:5],00,ocw_data[2:0]}; OCW3: A0=0, data={0,ocw_data[6:5],01,ocw_data[2:0]}.
REQ-028 ocw_ack pulses for the cycle after the OCW HOLD phase; FSM returns to READY that cycle; ocw_ack never asserted while busy=1.
REQ-029 ocw_err pulses one cycle, without any write, for each sampled cycle of ocw_req while in UNINIT, or ocw_req with ocw_sel=3 in READY.
REQ-030 ocw_req during ICW states is held off (no ack, no err) until READY.
REQ-031 start and ocw_req together in READY: start wins, re-initialization runs, OCW stays pending and is served after init completes.
REQ-032 After ocw_ack, a still-high ocw_req is treated as a new request (one write per ack).
REQ-033 Outside SETUP/STROBE/HOLD: WD=1, data_oe=0, A0 and data_out hold last value.

Reset
REQ-034 rst_n=0 asynchronously forces UNINIT, WD=1, A0=0, data_out=0x00, data_oe=0, busy=0, init_done=0, ocw_ack=0, ocw_err=0.
REQ-035 Reset during STROBE releases WD to 1 immediately, without waiting for clk; the aborted write is not retried.

Verification
REQ-036 WR_PULSE=2, start with sngl=1, ic4=0, base=0x08 -> writes (A0=0,0x12),(A0=1,0x40); WD low 2 cycles each; init_done high 8 cycles after start accept.
REQ-037 start with sngl=0, ic4=1, icw3=0x04, aeoi=1, ms=1, buf=1 -> 4 writes: ICW1=0x11, ICW2, ICW3=0x04, ICW4=0x0F.
REQ-038 ocw_req sel=0 data=0xA5 before init -> ocw_err pulse, WD stays 1; after init -> A0=1 write 0xA5, ocw_ack one cycle.
REQ-039 READY, ocw_req sel=2 data=0xFF -> A0=0, data 0x6F; sel=1 data=0xFF -> 0xE7; sel=3 -> ocw_err, no write.
REQ-040 start and ocw_req same cycle in READY -> full ICW sequence first, then OCW write, then ocw_ack.
REQ-041 rst_n low mid-STROBE of ICW2 -> WD=1 and all outputs at reset values same cycle; next start replays from ICW1.
